// File: rtl/panel_pkg.sv
// Shared types and sizes for the front-panel word entry path.
// Keys are indexed so the debouncers can be generated in a loop.
package panel_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    REQ     = 1'b1
  } state_t;

  localparam int NIBBLES_PER_WORD = 4;
  localparam int WORD_W           = 16;
  localparam int ADDR_W           = 8;
  localparam int NIBBLE_W         = 4;
  localparam int COUNT_W          = 3;
  localparam int NUM_KEYS         = 2;
  localparam int KEY_ENTER        = 0;
  localparam int KEY_CLEAR        = 1;
  localparam int DEB_CNT_W        = 16;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stability counter for one active-low key.
// Emits a single-cycle pulse when the debounced level falls (press only).
module key_debounce
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_key_n,
  output logic o_press
);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_level;
  logic                 r_press;
  logic [DEB_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th differing sample: accept it.
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/panel_loader.sv
// Front-panel entry: debounced enter/clear keys build a 16-bit word from nibbles
// and write it to memory at an auto-incrementing address over req/ack.
module panel_loader
  import panel_pkg::*;
#(
  parameter int unsigned       DEBOUNCE_CYCLES = 4,
  parameter logic [ADDR_W-1:0] START_ADDR      = 8'h00
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                KeyEnter_n,
  input  logic                KeyClear_n,
  input  logic [NIBBLE_W-1:0] Nibble,
  input  logic                WrAck,
  output logic                WrReq,
  output logic [ADDR_W-1:0]   WrAddr,
  output logic [WORD_W-1:0]   WrData,
  output logic [WORD_W-1:0]   Entry,
  output logic [COUNT_W-1:0]  Count
);

  logic [NUM_KEYS-1:0] w_keys_n;
  logic [NUM_KEYS-1:0] w_press;

  assign w_keys_n[KEY_ENTER] = KeyEnter_n;
  assign w_keys_n[KEY_CLEAR] = KeyClear_n;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .i_clk  (Clk),
        .i_srst (Reset),
        .i_key_n(w_keys_n[gi]),
        .o_press(w_press[gi])
      );
    end
  endgenerate

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_req;
  logic                 w_req_next;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    w_addr_next;
  logic [WORD_W-1:0]    r_data;
  logic [WORD_W-1:0]    w_data_next;
  logic [WORD_W-1:0]    r_entry;
  logic [WORD_W-1:0]    w_entry_next;
  logic [WORD_W-1:0]    w_entry_shift;
  logic [COUNT_W-1:0]   r_count;
  logic [COUNT_W-1:0]   w_count_next;

  assign w_entry_shift = {r_entry[WORD_W-NIBBLE_W-1:0], Nibble};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= COLLECT;
      r_req   <= 1'b0;
      r_addr  <= START_ADDR;
      r_data  <= '0;
      r_entry <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
      r_entry <= w_entry_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    w_entry_next = r_entry;
    w_count_next = r_count;
    case (r_state)
      COLLECT: begin
        // Clear beats a simultaneous enter; that nibble is lost.
        if (w_press[KEY_CLEAR]) begin
          w_entry_next = '0;
          w_count_next = '0;
        end else if (w_press[KEY_ENTER]) begin
          w_entry_next = w_entry_shift;
          w_count_next = r_count + 1'b1;
          if (r_count == COUNT_W'(NIBBLES_PER_WORD - 1)) begin
            w_data_next  = w_entry_shift;
            w_req_next   = 1'b1;
            w_state_next = REQ;
          end
        end
      end
      REQ: begin
        // Key pulses are dropped here; only the ack moves us on.
        if (r_req && WrAck) begin
          w_req_next   = 1'b0;
          w_addr_next  = r_addr + 1'b1;
          w_entry_next = '0;
          w_count_next = '0;
          w_state_next = COLLECT;
        end
      end
      default: begin
        w_state_next = COLLECT;
      end
    endcase
  end

  assign WrReq  = r_req;
  assign WrAddr = r_addr;
  assign WrData = r_data;
  assign Entry  = r_entry;
  assign Count  = r_count;

endmodule
